// File: rtl/fcsr_ctrl.sv
// FP CSR control: serialises fflags/frm/fcsr accesses behind in-flight FPU ops,
// accumulates sticky flags and resolves the dynamic rounding mode.
module fcsr_ctrl #(
    parameter int MAX_INFLIGHT = 7,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        csr_req,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic        csr_ack,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic        csr_busy,
    input  logic        fpu_issue,
    input  logic        fpu_retire,
    input  logic [4:0]  fpu_flags,
    output logic        fpu_full,
    output logic [4:0]  fflags,
    input  logic [2:0]  frm_q,
    output logic [2:0]  frm_d,
    output logic        frm_e,
    input  logic [2:0]  rm_in,
    output logic [2:0]  rm_eff,
    output logic        rm_illegal
);

    typedef enum logic [1:0] {IDLE, DRAIN, EXEC} state_t;

    localparam logic [11:0] A_FFLAGS = 12'h001;
    localparam logic [11:0] A_FRM    = 12'h002;
    localparam logic [11:0] A_FCSR   = 12'h003;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [11:0]      addr_q, addr_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             illegal_q, illegal_d;
    logic             frm_e_q, frm_e_d;
    logic [2:0]       frm_d_q, frm_d_d;

    logic [4:0] ret_flags, w_ff, new_ff;
    logic [2:0] w_rm, new_rm;
    logic       full, legal, hit_ff, hit_rm, is_wr;
    logic       unused_wdata;

    // Only the low byte ever reaches a field.
    assign unused_wdata = ^csr_wdata[31:8];

    assign full      = (inflight_q == CNT_W'(MAX_INFLIGHT));
    assign ret_flags = fpu_retire ? fpu_flags : 5'd0;

    assign hit_ff = (addr_q == A_FFLAGS) || (addr_q == A_FCSR);
    assign hit_rm = (addr_q == A_FRM)    || (addr_q == A_FCSR);
    assign legal  = hit_ff || hit_rm;
    assign is_wr  = (op_q != 2'b00);
    assign w_ff   = wdata_q[4:0];
    assign w_rm   = (addr_q == A_FCSR) ? wdata_q[7:5] : wdata_q[2:0];

    always_comb begin
        new_ff = fflags_q;
        new_rm = frm_q;
        case (op_q)
            2'b01: begin new_ff = w_ff;             new_rm = w_rm;            end
            2'b10: begin new_ff = fflags_q | w_ff;  new_rm = frm_q | w_rm;    end
            2'b11: begin new_ff = fflags_q & ~w_ff; new_rm = frm_q & ~w_rm;   end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        fflags_d   = fflags_q | ret_flags;
        addr_d     = addr_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        rdata_d    = 32'd0;
        illegal_d  = 1'b0;
        frm_e_d    = 1'b0;
        frm_d_d    = 3'd0;

        // Out-of-protocol issue when full or retire when empty leaves the count alone.
        if (fpu_issue && !fpu_retire && !full)
            inflight_d = inflight_q + 1'b1;
        else if (fpu_retire && !fpu_issue && (inflight_q != '0))
            inflight_d = inflight_q - 1'b1;

        case (state_q)
            IDLE: begin
                // The ack cycle itself is not a sampling cycle for a new request.
                if (csr_req && !ack_q) begin
                    addr_d  = csr_addr;
                    op_d    = csr_op;
                    wdata_d = csr_wdata[7:0];
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_q == '0)
                    state_d = EXEC;
            end
            EXEC: begin
                ack_d   = 1'b1;
                state_d = IDLE;
                if (legal) begin
                    case (addr_q)
                        A_FFLAGS: rdata_d = {27'd0, fflags_q};
                        A_FRM:    rdata_d = {29'd0, frm_q};
                        default:  rdata_d = {24'd0, frm_q, fflags_q};
                    endcase
                    if (is_wr && hit_rm) begin
                        frm_e_d = 1'b1;
                        frm_d_d = new_rm;
                    end
                    if (is_wr && hit_ff)
                        fflags_d = new_ff | ret_flags;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            fflags_q   <= 5'd0;
            addr_q     <= 12'd0;
            op_q       <= 2'd0;
            wdata_q    <= 8'd0;
            ack_q      <= 1'b0;
            rdata_q    <= 32'd0;
            illegal_q  <= 1'b0;
            frm_e_q    <= 1'b0;
            frm_d_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            fflags_q   <= fflags_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            illegal_q  <= illegal_d;
            frm_e_q    <= frm_e_d;
            frm_d_q    <= frm_d_d;
        end
    end

    assign csr_ack     = ack_q;
    assign csr_rdata   = rdata_q;
    assign csr_illegal = illegal_q;
    assign csr_busy    = (state_q != IDLE);
    assign fpu_full    = full;
    assign fflags      = fflags_q;
    assign frm_d       = frm_d_q;
    assign frm_e       = frm_e_q;

    assign rm_eff     = (rm_in == 3'd7) ? frm_q : rm_in;
    assign rm_illegal = (rm_in == 3'd5) || (rm_in == 3'd6) ||
                        ((rm_in == 3'd7) && (frm_q >= 3'd5));

endmodule

// File: tb/tb_fcsr_ctrl.sv
// Directed bench for fcsr_ctrl; models the external frm register.
module tb_fcsr_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        csr_req;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        csr_busy;
    logic        fpu_issue;
    logic        fpu_retire;
    logic [4:0]  fpu_flags;
    logic        fpu_full;
    logic [4:0]  fflags;
    logic [2:0]  frm_q;
    logic [2:0]  frm_d;
    logic        frm_e;
    logic [2:0]  rm_in;
    logic [2:0]  rm_eff;
    logic        rm_illegal;

    logic        frm_load;
    logic [2:0]  frm_load_val;
    int          passed = 0;
    int          total  = 0;

    fcsr_ctrl #(.MAX_INFLIGHT(7), .CNT_W(3)) dut (
        .clk(clk), .clrn(clrn),
        .csr_req(csr_req), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_ack(csr_ack), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .csr_busy(csr_busy),
        .fpu_issue(fpu_issue), .fpu_retire(fpu_retire), .fpu_flags(fpu_flags), .fpu_full(fpu_full),
        .fflags(fflags), .frm_q(frm_q), .frm_d(frm_d), .frm_e(frm_e),
        .rm_in(rm_in), .rm_eff(rm_eff), .rm_illegal(rm_illegal)
    );

    always #5 clk = ~clk;

    // External frm register, with a bench-side load port for rounding tests.
    always @(posedge clk or negedge clrn) begin
        if (!clrn)         frm_q <= 3'd0;
        else if (frm_e)    frm_q <= frm_d;
        else if (frm_load) frm_q <= frm_load_val;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic ill,
                          output logic fe, output logic [2:0] fd, output int stray);
        csr_req = 1'b1; csr_addr = a; csr_op = op; csr_wdata = wd;
        lat = 0; rd = '0; ill = 1'b0; fe = 1'b0; fd = '0; stray = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (csr_ack) begin
                lat = i; rd = csr_rdata; ill = csr_illegal; fe = frm_e; fd = frm_d;
                break;
            end
            if (frm_e) stray++;
        end
        csr_req = 1'b0;
        if (lat == 0) begin
            total++;
            $display("FAIL csr_timeout addr=%h: no ack within 20 cycles", a);
        end
    endtask

    task automatic test_reset;
        clrn = 1'b0; csr_req = 0; csr_addr = 0; csr_op = 0; csr_wdata = 0;
        fpu_issue = 0; fpu_retire = 0; fpu_flags = 0; rm_in = 0;
        frm_load = 0; frm_load_val = 0;
        #12;
        total++; if ({csr_ack, csr_illegal, frm_e, csr_busy, fpu_full} !== 5'b0)
            $display("FAIL reset_ctl got=%b want=00000", {csr_ack, csr_illegal, frm_e, csr_busy, fpu_full});
            else passed++;
        total++; if ({csr_rdata, fflags, frm_d} !== 40'd0)
            $display("FAIL reset_data rdata=%h fflags=%h frm_d=%h want 0", csr_rdata, fflags, frm_d);
            else passed++;
        @(negedge clk) clrn = 1'b1;
        tick();
    endtask

    task automatic test_read_empty;
        int lat, stray; logic [31:0] rd; logic ill, fe; logic [2:0] fd;
        do_csr(12'h003, 2'b00, 32'hFFFF_FFFF, lat, rd, ill, fe, fd, stray);
        total++; if (lat !== 3) $display("FAIL read_latency got=%0d want=3", lat); else passed++;
        total++; if (rd !== 32'd0) $display("FAIL read_rdata got=%h want=0", rd); else passed++;
        total++; if ({fe, stray[0], ill} !== 3'b0) $display("FAIL read_frm_e fe=%b stray=%0d ill=%b want 0", fe, stray, ill); else passed++;
        tick();
        total++; if (csr_ack !== 1'b0) $display("FAIL ack_one_cycle got=%b want=0", csr_ack); else passed++;
    endtask

    task automatic test_write_fcsr;
        int lat, stray; logic [31:0] rd; logic ill, fe; logic [2:0] fd;
        do_csr(12'h003, 2'b01, 32'h0000_00E3, lat, rd, ill, fe, fd, stray);
        total++; if ({fe, fd} !== 4'b1111) $display("FAIL wr_fcsr_frm fe=%b frm_d=%0d want 1/7", fe, fd); else passed++;
        total++; if (fflags !== 5'b00011) $display("FAIL wr_fcsr_fflags got=%h want=03", fflags); else passed++;
        total++; if (rd !== 32'd0) $display("FAIL wr_fcsr_rdata got=%h want=0", rd); else passed++;
        tick();
        total++; if (frm_q !== 3'd7) $display("FAIL wr_fcsr_frm_reg got=%0d want=7", frm_q); else passed++;
    endtask

    task automatic test_drain;
        logic early_ack, got_ack, fe; logic [2:0] fd; logic [31:0] rd;
        logic [4:0] fl [3];
        fl[0] = 5'h01; fl[1] = 5'h04; fl[2] = 5'h10;
        // Fresh reset so flags and frm start from zero.
        clrn = 1'b0; #2; @(negedge clk) clrn = 1'b1; tick();
        fpu_issue = 1'b1;
        repeat (3) tick();
        fpu_issue = 1'b0;
        csr_req = 1'b1; csr_addr = 12'h002; csr_op = 2'b01; csr_wdata = 32'd2;
        tick();
        early_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fpu_retire = 1'b1; fpu_flags = fl[i];
            tick();
            early_ack |= csr_ack;
        end
        fpu_retire = 1'b0; fpu_flags = 5'd0;
        tick();
        early_ack |= csr_ack;
        total++; if (early_ack !== 1'b0 || csr_busy !== 1'b1)
            $display("FAIL drain_hold ack=%b busy=%b want 0/1", early_ack, csr_busy); else passed++;
        tick();
        got_ack = csr_ack; fe = frm_e; fd = frm_d; rd = csr_rdata;
        csr_req = 1'b0;
        total++; if (got_ack !== 1'b1) $display("FAIL drain_ack got=%b want=1", got_ack); else passed++;
        total++; if ({fe, fd} !== 4'b1010) $display("FAIL drain_frm fe=%b frm_d=%0d want 1/2", fe, fd); else passed++;
        total++; if (fflags !== 5'h15) $display("FAIL drain_fflags got=%h want=15", fflags); else passed++;
        total++; if (rd !== 32'd0) $display("FAIL drain_rdata got=%h want=0", rd); else passed++;
        tick();
    endtask

    task automatic test_clear_illegal;
        int lat, stray; logic [31:0] rd; logic ill, fe; logic [2:0] fd;
        do_csr(12'h001, 2'b01, 32'h0000_001F, lat, rd, ill, fe, fd, stray);
        total++; if (fe !== 1'b0 || fflags !== 5'h1F) $display("FAIL wr_fflags fe=%b fflags=%h want 0/1f", fe, fflags); else passed++;
        tick();
        do_csr(12'h001, 2'b11, 32'h0000_0005, lat, rd, ill, fe, fd, stray);
        total++; if (rd !== 32'h1F) $display("FAIL clr_rdata got=%h want=1f", rd); else passed++;
        total++; if (fflags !== 5'h1A) $display("FAIL clr_fflags got=%h want=1a", fflags); else passed++;
        tick();
        do_csr(12'h004, 2'b01, 32'h0000_00FF, lat, rd, ill, fe, fd, stray);
        total++; if ({ill, fe} !== 2'b10) $display("FAIL illegal_flag ill=%b fe=%b want 1/0", ill, fe); else passed++;
        total++; if (rd !== 32'd0 || fflags !== 5'h1A) $display("FAIL illegal_nochg rdata=%h fflags=%h want 0/1a", rd, fflags); else passed++;
        tick();
        // frm is 2 here; set with 1 gives 3.
        do_csr(12'h002, 2'b10, 32'h0000_0001, lat, rd, ill, fe, fd, stray);
        total++; if ({rd[2:0], fe, fd} !== 7'b010_1_011) $display("FAIL set_frm rdata=%h fe=%b frm_d=%0d want 2/1/3", rd, fe, fd); else passed++;
        tick();
    endtask

    task automatic test_full_and_reset;
        logic ack_seen;
        fpu_issue = 1'b1;
        repeat (7) tick();
        total++; if (fpu_full !== 1'b1) $display("FAIL full_at7 got=%b want=1", fpu_full); else passed++;
        fpu_retire = 1'b1;
        tick();
        total++; if (fpu_full !== 1'b1) $display("FAIL full_both got=%b want=1", fpu_full); else passed++;
        fpu_retire = 1'b0;
        tick();
        total++; if (fpu_full !== 1'b1) $display("FAIL full_overissue got=%b want=1", fpu_full); else passed++;
        fpu_issue = 1'b0; fpu_retire = 1'b1;
        tick();
        fpu_retire = 1'b0;
        total++; if (fpu_full !== 1'b0) $display("FAIL full_retire got=%b want=0", fpu_full); else passed++;
        csr_req = 1'b1; csr_addr = 12'h003; csr_op = 2'b00;
        repeat (3) tick();
        total++; if ({csr_busy, csr_ack} !== 2'b10) $display("FAIL drain_busy busy=%b ack=%b want 1/0", csr_busy, csr_ack); else passed++;
        clrn = 1'b0;
        #1;
        total++; if ({csr_busy, csr_ack, fpu_full} !== 3'b0) $display("FAIL mid_reset busy=%b ack=%b full=%b want 0", csr_busy, csr_ack, fpu_full); else passed++;
        @(negedge clk) begin clrn = 1'b1; csr_req = 1'b0; end
        ack_seen = 1'b0;
        repeat (5) begin tick(); ack_seen |= csr_ack | csr_busy; end
        total++; if (ack_seen !== 1'b0) $display("FAIL reset_no_ack got=%b want=0", ack_seen); else passed++;
        // Count restarted at zero: seven issues must be needed to fill again.
        fpu_issue = 1'b1;
        repeat (6) tick();
        total++; if (fpu_full !== 1'b0) $display("FAIL count_cleared got=%b want=0", fpu_full); else passed++;
        fpu_issue = 1'b0;
        fpu_retire = 1'b1; repeat (6) tick(); fpu_retire = 1'b0;
    endtask

    task automatic test_rounding;
        frm_load = 1'b1; frm_load_val = 3'd3; tick(); frm_load = 1'b0;
        rm_in = 3'd7; #1;
        total++; if ({rm_eff, rm_illegal} !== 4'b011_0) $display("FAIL rm_dyn3 eff=%0d ill=%b want 3/0", rm_eff, rm_illegal); else passed++;
        frm_load = 1'b1; frm_load_val = 3'd6; tick(); frm_load = 1'b0;
        #1;
        total++; if ({rm_eff, rm_illegal} !== 4'b110_1) $display("FAIL rm_dyn6 eff=%0d ill=%b want 6/1", rm_eff, rm_illegal); else passed++;
        rm_in = 3'd5; #1;
        total++; if (rm_illegal !== 1'b1) $display("FAIL rm_5 ill=%b want 1", rm_illegal); else passed++;
        rm_in = 3'd2; #1;
        total++; if ({rm_eff, rm_illegal} !== 4'b010_0) $display("FAIL rm_2 eff=%0d ill=%b want 2/0", rm_eff, rm_illegal); else passed++;
    endtask

    initial begin
        test_reset();
        test_read_empty();
        test_write_fcsr();
        test_drain();
        test_clear_illegal();
        test_full_and_reset();
        test_rounding();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fcsr_ctrl.md
Name: fcsr_ctrl

Overview:
- Control stage directly upstream of the 3-bit enabled rounding-mode register (frm).
- Serialises CSR accesses to fflags/frm/fcsr against in-flight FPU operations and accumulates sticky exception flags from the FPU retire port.
- Produces the frm next-value and its write enable, and resolves each instruction's dynamic rounding mode.
- The frm register is external; this block reads its output back on frm_q.

Parameters:
- MAX_INFLIGHT, 7, maximum FPU ops in flight.
- CNT_W, 3, width of in-flight counter; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- csr_req  in  1  CSR access request; held high until csr_ack.
- csr_addr  in  12  0x001 fflags, 0x002 frm, 0x003 fcsr.
- csr_op  in  2  00 read, 01 write, 10 set, 11 clear.
- csr_wdata  in  32  write/set/clear operand.
- csr_ack  out  1  one-cycle completion pulse.
- csr_rdata  out  32  old CSR value, valid with csr_ack.
- csr_illegal  out  1  valid with csr_ack; unsupported address.
- csr_busy  out  1  high whenever state != IDLE; core stalls FPU issue on it.
- fpu_issue  in  1  op entering FPU pipeline.
- fpu_retire  in  1  op leaving FPU pipeline.
- fpu_flags  in  5  NV,DZ,OF,UF,NX of the retiring op.
- fpu_full  out  1  counter == MAX_INFLIGHT.
- fflags  out  5  sticky exception flags.
- frm_q  in  3  current frm (output of frm register).
- frm_d  out  3  next frm value.
- frm_e  out  1  frm register enable.
- rm_in  in  3  instruction rm field.
- rm_eff  out  3  effective rounding mode.
- rm_illegal  out  1  reserved rounding mode.

Behaviour:
- Reset (clrn low, asynchronous):
  - state = IDLE, inflight = 0, fflags = 0, latched request = 0.
  - csr_ack = 0, csr_rdata = 0, csr_illegal = 0, frm_e = 0, frm_d = 0.
- In-flight counter:
  - +1 on issue only; -1 on retire only; unchanged when both or neither occur.
  - Issue while fpu_full, or retire while 0: counter holds (protocol violation, bench flags it).
- Sticky flags: on fpu_retire, fflags <= fflags | fpu_flags, in every state.
- FSM states: IDLE, DRAIN, EXEC.
  - IDLE: on csr_req, latch addr/op/wdata and go to DRAIN.
  - DRAIN: stay while inflight != 0, or while inflight == 1 and retire occurs this cycle. Go to EXEC once inflight == 0 is registered.
  - EXEC: csr_ack = 1 for one cycle, then go to IDLE.
  - csr_req is not re-sampled until the cycle after ack.
- EXEC results (all registered outputs, asserted for exactly the EXEC cycle):
  - csr_rdata = old value:
    - fflags: {27'b0, fflags}
    - frm: {29'b0, frm_q}
    - fcsr: {24'b0, frm_q, fflags}
  - New field values by op:
    - write: new = wdata field
    - set: new = old | wdata field
    - clear: new = old & ~wdata field
    - read: no update
  - Field mapping: fflags uses wdata[4:0]; frm uses wdata[2:0]; fcsr uses wdata[4:0] for fflags and wdata[7:5] for frm.
  - frm_e = 1 with frm_d = new frm for any non-read op to frm or fcsr.
  - fflags takes the new value, ORed with fpu_flags if a retire coincides.
  - Illegal address: csr_illegal = 1, csr_rdata = 0, no state change.
- Latency: with the pipeline empty, req sampled at edge N gives ack high after edge N+2.
- Reset mid-operation: FSM returns to IDLE and no ack is issued; the requester must re-request.
- Dynamic rounding (combinational):
  - rm_eff = (rm_in == 7) ? frm_q : rm_in.
  - rm_illegal = 1 when rm_in is 5 or 6, or when rm_in == 7 and frm_q >= 5.

Test Plan:
- Reset, then read fcsr with the pipeline empty -> ack 2 cycles after req, rdata = 0, frm_e never pulses.
- Write fcsr with wdata = 0x000000E3, frm_q = 0 -> ack; frm_e pulse with frm_d = 7; fflags = 5'b00011; rdata = 0.
- Issue 3 ops, then req a write to frm with wdata = 2; retire the ops with flags 0x01, 0x04, 0x10 -> ack only after the 3rd retire + 1 cycle; frm_d = 2; fflags = 0x15.
- fflags = 0x1F, clear with wdata = 0x05 -> rdata = 0x1F, fflags = 0x1A; a second access to addr 0x004 -> csr_illegal = 1, rdata = 0, fflags still 0x1A.
- Issue and retire in the same cycle at inflight = 7 -> count stays 7 and fpu_full stays 1. Separately, assert clrn low while in DRAIN -> inflight = 0, IDLE, no ack.
- rm_in = 7 with frm_q = 3 -> rm_eff = 3, rm_illegal = 0. rm_in = 7 with frm_q = 6 -> rm_illegal = 1. rm_in = 5 -> rm_illegal = 1.
